// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_issue_ctrl
// Purpose  : RV32M multiply issue/writeback controller with one-entry
//            product reuse cache in front of a 33x33 signed multiplier core.
// Revision : 1.0 - initial release
// ============================================================================
module mul_issue_ctrl #(
    parameter bit REUSE_EN = 1'b1,
    parameter int RD_W     = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [31:0]     in_rs1,
    input  logic [31:0]     in_rs2,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [RD_W-1:0] out_rd,
    output logic [32:0]     mul_a,
    output logic [32:0]     mul_b,
    output logic            mul_req,
    input  logic            mul_rdy,
    input  logic [63:0]     mul_r
);

    localparam logic [1:0] c_OP_MUL    = 2'b00;
    localparam logic [1:0] c_OP_MULH   = 2'b01;
    localparam logic [1:0] c_OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_op;
    logic [RD_W-1:0] r_rd;
    logic [32:0]     r_a;
    logic [32:0]     r_b;
    logic [1:0]      r_cls;
    logic [63:0]     r_prod;
    logic            r_cache_vld;
    logic [31:0]     r_cache_rs1;
    logic [31:0]     r_cache_rs2;
    logic [1:0]      r_cache_cls;

    logic [1:0]      w_in_cls;
    logic            w_accept;
    logic            w_hit;
    logic            w_capture;
    logic            w_invalidate;

    // Sign class {a_signed, b_signed} of the offered op.
    assign w_in_cls = {(in_op == c_OP_MULH) || (in_op == c_OP_MULHSU),
                       (in_op == c_OP_MULH)};

    assign w_accept = (r_state == S_IDLE) && in_valid && !flush;

    // The low product word does not depend on sign class, so MUL matches any entry.
    assign w_hit = REUSE_EN && r_cache_vld &&
                   (in_rs1 == r_cache_rs1) && (in_rs2 == r_cache_rs2) &&
                   ((in_op == c_OP_MUL) || (w_in_cls == r_cache_cls));

    assign w_capture    = (r_state == S_BUSY) && mul_rdy && !flush;
    assign w_invalidate = ((r_state == S_BUSY) && flush) ||
                          ((r_state == S_DRAIN) && mul_rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_req   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next = w_hit ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                mul_req = 1'b1;
                if (mul_rdy) begin
                    w_next = flush ? S_IDLE : S_DONE;
                end else if (flush) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The core cannot be aborted; keep requesting until it answers.
                mul_req = 1'b1;
                if (mul_rdy) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready || flush) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= 2'b00;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cls       <= 2'b00;
            r_prod      <= '0;
            r_cache_vld <= 1'b0;
            r_cache_rs1 <= '0;
            r_cache_rs2 <= '0;
            r_cache_cls <= 2'b00;
        end else begin
            if (w_accept) begin
                r_op  <= in_op;
                r_rd  <= in_rd;
                r_a   <= {w_in_cls[1] & in_rs1[31], in_rs1};
                r_b   <= {w_in_cls[0] & in_rs2[31], in_rs2};
                r_cls <= w_in_cls;
            end
            // r_prod only changes together with the cache, so a hit reads it directly.
            if (w_capture) begin
                r_prod      <= mul_r;
                r_cache_vld <= 1'b1;
                r_cache_rs1 <= r_a[31:0];
                r_cache_rs2 <= r_b[31:0];
                r_cache_cls <= r_cls;
            end else if (w_invalidate) begin
                r_cache_vld <= 1'b0;
            end
        end
    end

    assign mul_a    = r_a;
    assign mul_b    = r_b;
    assign out_rd   = r_rd;
    assign out_data = (r_op == c_OP_MUL) ? r_prod[31:0] : r_prod[63:32];

endmodule
`default_nettype wire
